// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, oversampling constants, vote helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] SAMPLE_T0 = TICK_W'(7);
  localparam logic [TICK_W-1:0] SAMPLE_T1 = TICK_W'(8);
  localparam logic [TICK_W-1:0] SAMPLE_T2 = TICK_W'(9);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

  // 2-of-3 majority used for every bit decision
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous serial inputs; resets to line-idle (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 3-sample majority vote, LSB-first, no parity.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned STOP_W = 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [STOP_W-1:0]    stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 samp0_q, samp0_d;
  logic                 samp1_q, samp1_d;
  logic                 err_q, err_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_valid_d, frame_err_d, rx_busy_d;

  logic vote, at_t0, at_t1, at_t2, at_last;

  assign vote    = majority3(samp0_q, samp1_q, rx_s);
  assign at_t0   = baud_tick_16x && (tick_q == SAMPLE_T0);
  assign at_t1   = baud_tick_16x && (tick_q == SAMPLE_T1);
  assign at_t2   = baud_tick_16x && (tick_q == SAMPLE_T2);
  assign at_last = baud_tick_16x && (tick_q == LAST_TICK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; all transitions happen on tick cycles only
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (baud_tick_16x && armed_q && !rx_s) state_d = ST_START;
      ST_START: begin
        if (at_t2 && vote)  state_d = ST_IDLE;
        else if (at_last)   state_d = ST_DATA;
      end
      ST_DATA:  if (at_last && bit_q == BIT_LAST) state_d = ST_STOP;
      ST_STOP:  if (at_t2 && stop_q == STOP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    tick_d      = tick_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    samp0_d     = samp0_q;
    samp1_d     = samp1_q;
    err_d       = err_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_busy_d   = (state_d != ST_IDLE);

    if (baud_tick_16x) begin
      tick_d = TICK_W'(tick_q + TICK_W'(1));
      if (at_t0) samp0_d = rx_s;
      if (at_t1) samp1_d = rx_s;
      case (state_q)
        ST_IDLE: begin
          tick_d  = '0;
          // a start is only armed after the line has been seen high (break recovery)
          armed_d = rx_s;
        end
        ST_START: begin
          if (state_d == ST_IDLE) tick_d = '0;
          if (at_last)            bit_d  = '0;
        end
        ST_DATA: begin
          if (at_t2) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (at_last) begin
            if (bit_q == BIT_LAST) stop_d = '0;
            else                   bit_d  = BIT_W'(bit_q + BIT_W'(1));
          end
        end
        ST_STOP: begin
          if (at_t2) begin
            err_d = err_q | ~vote;
            // final stop ends mid-bit to leave margin for a back-to-back start edge
            if (stop_q == STOP_LAST) begin
              rx_data_d   = shift_q;
              rx_valid_d  = 1'b1;
              frame_err_d = err_q | ~vote;
              err_d       = 1'b0;
              tick_d      = '0;
            end
          end else if (at_last) begin
            stop_d = STOP_W'(stop_q + STOP_W'(1));
          end
        end
        default: tick_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= '0;
      bit_q     <= '0;
      stop_q    <= '0;
      shift_q   <= '0;
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      samp0_q   <= samp0_d;
      samp1_q   <= samp1_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
      rx_busy   <= rx_busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: bench-driven TX waveform, one-stop and two-stop receivers.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick_16x = 1'b0;
  logic       rx;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, rx_valid2;
  logic       frame_err, frame_err2;
  logic       rx_busy, rx_busy2;

  int n_tests = 0;
  int n_fail  = 0;
  int stray   = 0;
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  uart_rx_core #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick_16x), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_rx_core #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick_16x), .rx(rx),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .frame_err(frame_err2), .rx_busy(rx_busy2)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      baud_tick_16x = (div == 0);
      div = (div == 3) ? 0 : div + 1;
    end
  end

  // Record every delivered word as {frame_err, data}
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid)  q1.push_back({frame_err, rx_data});
      if (rx_valid2) q2.push_back({frame_err2, rx_data2});
      if (frame_err && !rx_valid) stray++;
      if (frame_err2 && !rx_valid2) stray++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns after the n-th tick edge, 1 time unit past the edge
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick_16x) @(posedge clk);
    end
    #1;
  endtask

  function automatic logic [8:0] pop_word(input int sel);
    if (sel == 1) begin
      if (q1.size() == 0) return 'x;
      return q1.pop_front();
    end
    if (q2.size() == 0) return 'x;
    return q2.pop_front();
  endfunction

  task automatic expect_words(input string tag, input int sel, input int n,
                              input logic [7:0] d0, input logic e0,
                              input logic [7:0] d1, input logic e1);
    logic [8:0] w;
    check({tag, "_count"}, 32'((sel == 1) ? q1.size() : q2.size()), 32'(n));
    w = pop_word(sel);
    check({tag, "_data0"}, 32'(w[7:0]), 32'(d0));
    check({tag, "_err0"},  32'(w[8]),   32'(e0));
    if (n == 2) begin
      w = pop_word(sel);
      check({tag, "_data1"}, 32'(w[7:0]), 32'(d1));
      check({tag, "_err1"},  32'(w[8]),   32'(e1));
    end
  endtask

  // Drive one frame; glitch_bit inverts one tick around the mid sample, abort_bit resets mid-bit
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int nstop,
                            input int glitch_bit, input int abort_bit);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx    = 1'b1;
        rst_n = 1'b1;
        return;
      end
      if (i == glitch_bit) begin
        wait_ticks(9);
        rx = ~d[i];
        wait_ticks(1);
        rx = d[i];
        wait_ticks(6);
      end else begin
        wait_ticks(16);
      end
    end
    rx = stop_v;
    wait_ticks(16);
    if (nstop == 2) begin
      rx = 1'b1;
      wait_ticks(16);
    end
    rx = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(rx_data),   32'h0);
    check("rst_valid", 32'(rx_valid),  32'h0);
    check("rst_err",   32'(frame_err), 32'h0);
    check("rst_busy",  32'(rx_busy),   32'h0);
    rst_n = 1'b1;
    wait_ticks(8);

    send_frame(8'hA5, 1'b1, 1, -1, -1);
    expect_words("a5", 1, 1, 8'hA5, 1'b0, 8'h00, 1'b0);
    check("a5_busy_after", 32'(rx_busy), 32'h0);
    wait_ticks(4);

    // Four-tick low glitch: START rejects it at its mid-bit vote
    rx = 1'b0;
    wait_ticks(4);
    check("glitch_busy_rise", 32'(rx_busy), 32'h1);
    rx = 1'b1;
    wait_ticks(6);
    check("glitch_busy_hold", 32'(rx_busy), 32'h1);
    wait_ticks(1);
    check("glitch_busy_fall", 32'(rx_busy), 32'h0);
    wait_ticks(8);
    check("glitch_no_valid", 32'(q1.size()), 32'h0);
    send_frame(8'h3C, 1'b1, 1, -1, -1);
    expect_words("3c", 1, 1, 8'h3C, 1'b0, 8'h00, 1'b0);
    wait_ticks(4);

    send_frame(8'h55, 1'b0, 1, -1, -1);
    expect_words("ferr", 1, 1, 8'h55, 1'b1, 8'h00, 1'b0);
    wait_ticks(4);
    send_frame(8'h81, 1'b1, 1, -1, -1);
    expect_words("81", 1, 1, 8'h81, 1'b0, 8'h00, 1'b0);
    wait_ticks(4);

    send_frame(8'h00, 1'b1, 1, -1, -1);
    send_frame(8'hFF, 1'b1, 1, -1, -1);
    expect_words("b2b", 1, 2, 8'h00, 1'b0, 8'hFF, 1'b0);
    wait_ticks(4);

    send_frame(8'hF0, 1'b1, 1, 3, -1);
    expect_words("vote", 1, 1, 8'hF0, 1'b0, 8'h00, 1'b0);
    wait_ticks(4);

    send_frame(8'h99, 1'b1, 1, -1, 4);
    wait_ticks(20);
    check("abort_no_valid", 32'(q1.size()), 32'h0);
    check("abort_busy",     32'(rx_busy),   32'h0);
    check("abort_data",     32'(rx_data),   32'h0);
    send_frame(8'h7E, 1'b1, 1, -1, -1);
    expect_words("7e", 1, 1, 8'h7E, 1'b0, 8'h00, 1'b0);

    // Long idle lets the two-stop receiver resync before its own frame
    wait_ticks(200);
    q1.delete();
    q2.delete();
    send_frame(8'h7E, 1'b1, 2, -1, -1);
    expect_words("7e_s1", 1, 1, 8'h7E, 1'b0, 8'h00, 1'b0);
    expect_words("7e_s2", 2, 1, 8'h7E, 1'b0, 8'h00, 1'b0);
    check("stray_err", 32'(stray), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
